// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // Index to one-hot, used when loading the grant register.
  function automatic logic [N_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
    return N_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority finder: first asserted request at or above ptr, wrapping.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  win_id,
  output logic             any
);

  always_comb begin
    logic [ID_W-1:0] idx;
    win_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + ID_W'(i);
      if (!any && req[idx]) begin
        win_id = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with hold limit and one-cycle turnaround.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam bit HOLD_EN = (MAX_HOLD > 0);

  arb_state_t       state;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [ID_W-1:0]  win_id_c;
  logic             win_any_c;
  logic             owner_req_c;
  logic             limit_hit_c;
  logic             release_c;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr),
    .win_id (win_id_c),
    .any    (win_any_c)
  );

  always_comb begin
    owner_req_c = req[grant_id];
    limit_hit_c = HOLD_EN && (hold_cnt == HOLD_LAST);
    release_c   = done || !owner_req_c || limit_hit_c;
  end

  // FSM, pointer, hold counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (go && win_any_c) begin
            state       <= GRANT;
            grant_id    <= win_id_c;
            grant       <= id2onehot(win_id_c);
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        GRANT: begin
          if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
          if (release_c) begin
            state       <= GAP;
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= grant_id + ID_W'(1);
            // A limit release only counts as a timeout if the owner still wanted it.
            timeout     <= limit_hit_c && !done && owner_req_c;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with hand-computed expected values.
module tb_rr_arbiter8;

  logic       clk;
  logic       reset;
  logic       go;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  int n_checks;
  int n_errors;

  rr_arbiter8 #(.MAX_HOLD(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one active edge; return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    go    = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    go    = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    @(negedge clk);
    tick();

    check("rst_grant", 32'(grant), 32'h00);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_valid", 32'(grant_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);

    // Reset mid-grant
    reset = 1'b0;
    req = 8'h20;
    go  = 1'b1;
    tick();
    check("mid_grant", 32'(grant), 32'h20);
    check("mid_grant_id", 32'(grant_id), 32'd5);
    check("mid_valid", 32'(grant_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_grant", 32'(grant), 32'h00);
    check("async_rst_valid", 32'(grant_valid), 32'd0);
    check("async_rst_id", 32'(grant_id), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    req = 8'h01;
    go  = 1'b1;
    tick();
    check("post_rst_grant", 32'(grant), 32'h01);

    // Rotation with req=FF and done one cycle after each grant
    do_reset();
    req = 8'hFF;
    go  = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) begin
      check("rot_grant", 32'(grant), 32'(8'h01 << (k % 8)));
      check("rot_id", 32'(grant_id), 32'(k % 8));
      done = 1'b1;
      tick();
      done = 1'b0;
      check("rot_gap0", 32'(grant), 32'h00);
      tick();
      check("rot_gap1", 32'(grant), 32'h00);
      tick();
    end
    check("rot_wrap_next", 32'(grant), 32'h02);
    req = 8'h00;
    go  = 1'b0;
    tick();
    tick();

    // Pointer skip: after granting 5, ptr=6, req=21 picks 0 then 5
    do_reset();
    req = 8'h20;
    go  = 1'b1;
    tick();
    check("skip_first", 32'(grant), 32'h20);
    done = 1'b1;
    go   = 1'b0;
    tick();
    done = 1'b0;
    tick();
    req = 8'h21;
    go  = 1'b1;
    tick();
    check("skip_grant", 32'(grant), 32'h01);
    check("skip_id", 32'(grant_id), 32'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    check("skip_ptr1", 32'(grant), 32'h20);
    req = 8'h00;
    go  = 1'b0;
    tick();
    tick();

    // Timeout: req=08 held, no done
    do_reset();
    req = 8'h08;
    go  = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      check("to_hold", 32'(grant), 32'h08);
      check("to_no_pulse", 32'(timeout), 32'd0);
      tick();
    end
    check("to_drop", 32'(grant), 32'h00);
    check("to_pulse", 32'(timeout), 32'd1);
    tick();
    check("to_gap_idle", 32'(grant), 32'h00);
    check("to_pulse_end", 32'(timeout), 32'd0);
    tick();
    check("to_regrant", 32'(grant), 32'h08);
    check("to_regrant_id", 32'(grant_id), 32'd3);

    // done coinciding with the limit on cycle 16
    for (int i = 0; i < 15; i++) begin
      check("dl_hold", 32'(grant), 32'h08);
      tick();
    end
    check("dl_last", 32'(grant), 32'h08);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("dl_drop", 32'(grant), 32'h00);
    check("dl_no_pulse", 32'(timeout), 32'd0);

    // Go gating and request drop
    go  = 1'b0;
    req = 8'h10;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("gate_hold", 32'(grant), 32'h00);
    end
    go = 1'b1;
    tick();
    check("gate_grant", 32'(grant), 32'h10);
    check("gate_id", 32'(grant_id), 32'd4);
    req = 8'h00;
    tick();
    check("drop_grant", 32'(grant), 32'h00);
    check("drop_no_pulse", 32'(timeout), 32'd0);
    check("drop_id_gap", 32'(grant_id), 32'd4);
    tick();
    check("drop_id_idle", 32'(grant_id), 32'd4);
    check("drop_valid", 32'(grant_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
